// File: rtl/text_console.sv
// rtl/text_console.sv - character-cell text console with host byte input, cell RAM, cursor and blink
//
// Accepts ASCII bytes from a host and keeps a COLS x ROWS character RAM.
// The cursor control codes it handles are CR, LF, BS and FF. The display side
// reads the RAM once per pixel, one cycle after the pixel coordinates arrive.
//
// Ports:
//   px_clk       pixel clock; every register uses its rising edge
//   resetn       asynchronous active-low reset
//   in_data      ASCII byte from the host
//   in_valid     in_data is valid
//   in_ready     console accepts a byte this cycle (IDLE only)
//   px_x, px_y   current pixel column / row from the sync stage
//   activevideo  pixel is in the visible area
//   frame_tick   one-cycle pulse per frame, drives the cursor blink
//   char_out     character code for the pixel presented one cycle earlier
//   cursor_here  that same pixel lies in the visible cursor cell
//   cursor_col   current cursor column
//   cursor_row   current cursor row
module text_console #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int BLINK_LOG2 = 5
) (
  input  logic       px_clk,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  input  logic       activevideo,
  input  logic       frame_tick,
  output logic [7:0] char_out,
  output logic       cursor_here,
  output logic [6:0] cursor_col,
  output logic [5:0] cursor_row
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
  localparam logic [5:0]        ROW_LAST  = 6'(ROWS - 1);
  localparam logic [9:0]        COLS_P    = 10'(COLS);
  localparam logic [9:0]        ROWS_P    = 10'(ROWS);
  localparam logic [7:0]        SPACE     = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_LINE,
    CLEAR_ALL
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic [6:0]          col_q, col_d;
  logic [5:0]          row_q, row_d;
  logic [BLINK_LOG2:0] frame_q;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [7:0]          wdata;

  logic [7:0]          mem [CELLS];

  logic [ADDR_W-1:0]   line_base;
  logic [ADDR_W-1:0]   cur_addr;
  logic [5:0]          row_adv;
  logic                printable;

  logic [6:0]          cell_x;
  logic [6:0]          cell_y;
  logic [ADDR_W-1:0]   rd_addr;
  logic                in_range;
  logic                at_cursor;
  logic                unused_px;

  assign line_base = ADDR_W'(row_q) * COLS_A;
  assign cur_addr  = line_base + ADDR_W'(col_q);
  assign row_adv   = (row_q == ROW_LAST) ? 6'd0 : row_q + 6'd1;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  // Pixels map to 8x8 cells; the low three coordinate bits only select
  // the pixel within the glyph, which is the font stage's business.
  assign cell_x    = px_x[9:3];
  assign cell_y    = px_y[9:3];
  assign unused_px = ^{px_x[2:0], px_y[2:0]};
  assign rd_addr   = ADDR_W'(cell_y) * COLS_A + ADDR_W'(cell_x);
  assign in_range  = activevideo && ({3'b000, cell_x} < COLS_P) && ({3'b000, cell_y} < ROWS_P);
  assign at_cursor = (cell_x == col_q) && (cell_y == {1'b0, row_q});

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    col_d    = col_q;
    row_d    = row_q;
    we       = 1'b0;
    waddr    = cur_addr;
    wdata    = SPACE;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (printable) begin
            we    = 1'b1;
            wdata = in_data;
            if (col_q == COL_LAST) begin
              col_d   = 7'd0;
              row_d   = row_adv;
              clr_d   = '0;
              state_d = CLEAR_LINE;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (in_data == 8'h0D) begin
            col_d = 7'd0;
          end else if (in_data == 8'h0A) begin
            row_d   = row_adv;
            clr_d   = '0;
            state_d = CLEAR_LINE;
          end else if (in_data == 8'h08) begin
            if (col_q != 7'd0) begin
              col_d = col_q - 7'd1;
              we    = 1'b1;
              waddr = cur_addr - ONE_A;
            end
          end else if (in_data == 8'h0C) begin
            col_d   = 7'd0;
            row_d   = 6'd0;
            clr_d   = '0;
            state_d = CLEAR_ALL;
          end
        end
      end
      CLEAR_LINE: begin
        // row_q already points at the freshly entered line
        we    = 1'b1;
        waddr = line_base + clr_q;
        if (clr_q == LINE_LAST) begin
          clr_d   = '0;
          state_d = IDLE;
        end else begin
          clr_d = clr_q + ONE_A;
        end
      end
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = clr_q;
        if (clr_q == LAST_ADDR) begin
          clr_d   = '0;
          state_d = IDLE;
        end else begin
          clr_d = clr_q + ONE_A;
        end
      end
      default: begin
        clr_d   = '0;
        state_d = CLEAR_ALL;
      end
    endcase
  end

  always_ff @(posedge px_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= CLEAR_ALL;
      clr_q       <= '0;
      col_q       <= 7'd0;
      row_q       <= 6'd0;
      frame_q     <= '0;
      char_out    <= 8'h00;
      cursor_here <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (frame_tick) begin
        frame_q <= frame_q + {{BLINK_LOG2{1'b0}}, 1'b1};
      end
      // Non-blocking read beside the write below gives read-before-write.
      char_out    <= in_range ? mem[rd_addr] : 8'h00;
      cursor_here <= in_range && at_cursor && !frame_q[BLINK_LOG2];
    end
  end

  // RAM contents survive reset; writes are held off only while it is asserted.
  always_ff @(posedge px_clk) begin
    if (we && resetn) begin
      mem[waddr] <= wdata;
    end
  end

  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
